pll_drp_ctrl: RTL and testbench

PLL_DRP_CTRL -- requirements
Module: pll_drp_ctrl

---
 rtl/pll_drp_pkg.sv | 31 +++
 rtl/drp_timer.sv | 34 +++
 rtl/pll_drp_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pll_drp_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_drp_pkg.sv
// Purpose: shared types and widths for the PLL DRP reconfiguration controller.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package pll_drp_pkg;

    localparam int DRP_ADDR_W = 7;
    localparam int DRP_DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        READ,
        WAIT_R,
        WRITE,
        WAIT_W,
        LOCK,
        DONE
    } state_t;

    // One captured register-update item; the address lives in daddr itself.
    typedef struct packed {
        logic [DRP_DATA_W-1:0] mask;
        logic [DRP_DATA_W-1:0] data;
        logic                  last;
    } cfg_item_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/drp_timer.sv
// Purpose: per-state cycle counter with a saturating count and limit compare.
// Latency: clear takes effect on the next edge; expired is combinational from the count.
// Backpressure: none; enable stalls the count.
//
// Ports: clk/rst clock and async active-high reset; clear restarts the count at 0;
// enable advances it by one per cycle; expired is high once limit cycles have
// been spent (the current cycle included) since the last clear.
module drp_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

    // cnt counts completed cycles in the state, so cnt+1 includes the present one.
    assign expired = ({1'b0, cnt} + {{W{1'b0}}, 1'b1}) >= {1'b0, limit};

endmodule

// File: rtl/pll_drp_ctrl.sv
// Purpose: walks a list of read-modify-write DRP updates into a PLL held in reset, then waits for lock.
// Latency: per item 1 fetch + 1 read + DRDY wait + 1 write + DRDY wait; done pulse 1 cycle after LOCKED.
// Backpressure: cfg_ready only in FETCH; FETCH waits forever, DRDY and LOCKED waits time out into serr.
//
// Ports: dclk/rst clock and async active-high reset; sen starts a sequence;
// cfg_* item handshake (mask bit 1 keeps the old register bit); daddr/di/den/dwe
// and drp_do/drdy form the DRP master port; pll_rst/locked talk to the PLL;
// busy, srdy (done pulse) and serr (sticky error) report status.
module pll_drp_ctrl
    import pll_drp_pkg::*;
#(
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 4096
) (
    input  logic                  dclk,
    input  logic                  rst,
    input  logic                  sen,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [DRP_ADDR_W-1:0] cfg_addr,
    input  logic [DRP_DATA_W-1:0] cfg_mask,
    input  logic [DRP_DATA_W-1:0] cfg_data,
    input  logic                  cfg_last,
    output logic [DRP_ADDR_W-1:0] daddr,
    output logic [DRP_DATA_W-1:0] di,
    output logic                  den,
    output logic                  dwe,
    input  logic [DRP_DATA_W-1:0] drp_do,
    input  logic                  drdy,
    output logic                  pll_rst,
    input  logic                  locked,
    output logic                  busy,
    output logic                  srdy,
    output logic                  serr
);

    localparam int CNT_W = $clog2(max_int(DRDY_TIMEOUT, LOCK_TIMEOUT)) + 1;
    localparam logic [CNT_W-1:0] DRDY_LIM = CNT_W'(DRDY_TIMEOUT);
    localparam logic [CNT_W-1:0] LOCK_LIM = CNT_W'(LOCK_TIMEOUT);

    state_t     state;
    cfg_item_t  item;
    logic       state_exit;
    logic       tmr_exp;
    logic [CNT_W-1:0] tmr_limit;

    // The timer must read 0 on the first cycle of every state, so it is cleared
    // on the edge that leaves the current state rather than after entry.
    always_comb begin
        state_exit = 1'b0;
        case (state)
            IDLE:           state_exit = sen;
            FETCH:          state_exit = cfg_valid;
            READ, WRITE:    state_exit = 1'b1;
            WAIT_R, WAIT_W: state_exit = drdy || tmr_exp;
            LOCK:           state_exit = locked || tmr_exp;
            DONE:           state_exit = 1'b1;
            default:        state_exit = 1'b1;
        endcase
    end

    assign tmr_limit = (state == LOCK) ? LOCK_LIM : DRDY_LIM;

    drp_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk     (dclk),
        .rst     (rst),
        .clear   (state_exit),
        .enable  (1'b1),
        .limit   (tmr_limit),
        .expired (tmr_exp)
    );

    always_ff @(posedge dclk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            item      <= '0;
            daddr     <= '0;
            di        <= '0;
            den       <= 1'b0;
            dwe       <= 1'b0;
            pll_rst   <= 1'b0;
            cfg_ready <= 1'b0;
            busy      <= 1'b0;
            srdy      <= 1'b0;
            serr      <= 1'b0;
        end else begin
            // den/dwe/srdy are single-cycle strobes; daddr and di simply hold.
            den  <= 1'b0;
            dwe  <= 1'b0;
            srdy <= 1'b0;
            case (state)
                IDLE: begin
                    if (sen) begin
                        state     <= FETCH;
                        pll_rst   <= 1'b1;
                        busy      <= 1'b1;
                        serr      <= 1'b0;
                        cfg_ready <= 1'b1;
                    end
                end
                FETCH: begin
                    if (cfg_valid) begin
                        item      <= '{mask: cfg_mask, data: cfg_data, last: cfg_last};
                        daddr     <= cfg_addr;
                        den       <= 1'b1;
                        cfg_ready <= 1'b0;
                        state     <= READ;
                    end
                end
                READ: begin
                    state <= WAIT_R;
                end
                WAIT_R: begin
                    if (drdy) begin
                        di    <= (drp_do & item.mask) | (item.data & ~item.mask);
                        den   <= 1'b1;
                        dwe   <= 1'b1;
                        state <= WRITE;
                    end else if (tmr_exp) begin
                        serr    <= 1'b1;
                        pll_rst <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                WRITE: begin
                    state <= WAIT_W;
                end
                WAIT_W: begin
                    if (drdy) begin
                        if (item.last) begin
                            pll_rst <= 1'b0;
                            state   <= LOCK;
                        end else begin
                            cfg_ready <= 1'b1;
                            state     <= FETCH;
                        end
                    end else if (tmr_exp) begin
                        serr    <= 1'b1;
                        pll_rst <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                LOCK: begin
                    if (locked) begin
                        srdy  <= 1'b1;
                        state <= DONE;
                    end else if (tmr_exp) begin
                        serr    <= 1'b1;
                        pll_rst <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_drp_ctrl.sv
// Purpose: directed self-checking bench for pll_drp_ctrl with a small DRP register-file PLL model.
// Latency: model answers each DEN with DRDY after a programmable number of cycles.
// Backpressure: model can withhold DRDY; LOCKED is driven directly by the stimulus.
module tb_pll_drp_ctrl;

    logic        dclk = 1'b0;
    logic        rst = 1'b1;
    logic        sen = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [6:0]  cfg_addr = '0;
    logic [15:0] cfg_mask = '0;
    logic [15:0] cfg_data = '0;
    logic        cfg_last = 1'b0;
    logic [6:0]  daddr;
    logic [15:0] di;
    logic        den;
    logic        dwe;
    logic [15:0] drp_do = '0;
    logic        drdy = 1'b0;
    logic        pll_rst;
    logic        locked = 1'b0;
    logic        busy;
    logic        srdy;
    logic        serr;

    pll_drp_ctrl #(
        .DRDY_TIMEOUT (64),
        .LOCK_TIMEOUT (4096)
    ) dut (
        .dclk      (dclk),
        .rst       (rst),
        .sen       (sen),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_addr  (cfg_addr),
        .cfg_mask  (cfg_mask),
        .cfg_data  (cfg_data),
        .cfg_last  (cfg_last),
        .daddr     (daddr),
        .di        (di),
        .den       (den),
        .dwe       (dwe),
        .drp_do    (drp_do),
        .drdy      (drdy),
        .pll_rst   (pll_rst),
        .locked    (locked),
        .busy      (busy),
        .srdy      (srdy),
        .serr      (serr)
    );

    always #5 dclk = ~dclk;

    // ---------------- PLL DRP model (observes and drives on the falling edge)
    bit          resp_en = 1'b1;
    int          lat = 2;
    bit          drdy_force = 1'b0;
    logic [15:0] mem [0:127];
    bit          written [0:127];
    int          pend = 0;
    logic [15:0] rd_q = '0;
    int          n_rd = 0;
    int          n_wr = 0;
    int          n_srdy = 0;
    int          n_ovl = 0;
    logic [6:0]  rd_log[$];
    logic [6:0]  wr_alog[$];
    logic [15:0] wr_dlog[$];
    logic        wr_rstlog[$];

    function automatic logic [15:0] init_val(input logic [6:0] a);
        case (a)
            7'h08:   return 16'hFFFF;
            7'h10:   return 16'h0000;
            7'h11:   return 16'h1234;
            7'h12:   return 16'hFFFF;
            default: return 16'hC3C3 ^ {9'd0, a};
        endcase
    endfunction

    always @(negedge dclk) begin
        drdy = drdy_force;
        if (pend > 0) begin
            pend = pend - 1;
            if (pend == 0) begin
                drdy   = 1'b1;
                drp_do = rd_q;
            end
        end
        if (srdy) n_srdy++;
        if (den) begin
            if (pend > 0) n_ovl++;
            if (dwe) begin
                mem[daddr]     = di;
                written[daddr] = 1'b1;
                wr_alog.push_back(daddr);
                wr_dlog.push_back(di);
                wr_rstlog.push_back(pll_rst);
                n_wr++;
            end else begin
                rd_q = written[daddr] ? mem[daddr] : init_val(daddr);
                rd_log.push_back(daddr);
                n_rd++;
            end
            if (resp_en) pend = lat;
        end
    end

    // ---------------- checking
    int n_vec = 0;
    int n_miss = 0;
    int wait_tgt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic cond(input int which);
        case (which)
            0:       return busy && !pll_rst;   // sitting in LOCK
            1:       return srdy;
            2:       return serr;
            3:       return cfg_ready;
            4:       return n_wr >= wait_tgt;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_sig(input int which, input int budget, input string tag);
        int c;
        c = 0;
        while (!cond(which) && c < budget) begin
            @(negedge dclk);
            c++;
        end
        if (!cond(which)) chk(tag, {31'd0, cond(which)}, 32'd1);
    endtask

    task automatic pulse_sen();
        sen = 1'b1;
        @(negedge dclk);
        sen = 1'b0;
    endtask

    task automatic send_item(input logic [6:0] a, input logic [15:0] m,
                             input logic [15:0] d, input logic l);
        wait_sig(3, 300, "item_ready_timeout");
        cfg_addr  = a;
        cfg_mask  = m;
        cfg_data  = d;
        cfg_last  = l;
        cfg_valid = 1'b1;
        @(negedge dclk);
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
    endtask

    task automatic finish_lock(input string tag);
        wait_sig(0, 400, {tag, "_lock_entry"});
        locked = 1'b1;
        wait_sig(1, 5, {tag, "_srdy"});
        @(negedge dclk);
        locked = 1'b0;
        @(negedge dclk);
    endtask

    logic [6:0]  t2_a [0:2] = '{7'h10, 7'h11, 7'h12};
    logic [15:0] t2_m [0:2] = '{16'hFF00, 16'h0F0F, 16'h0000};
    logic [15:0] t2_d [0:2] = '{16'h00AB, 16'hA0A0, 16'h5A5A};
    logic [15:0] t2_e [0:2] = '{16'h00AB, 16'hA2A4, 16'h5A5A};

    initial begin
        int r0, w0, s0, cnt;

        // reset values
        @(negedge dclk);
        @(negedge dclk);
        chk("rst_flags", {den, dwe, pll_rst, cfg_ready, busy, srdy, serr}, 0);
        chk("rst_daddr", daddr, 0);
        chk("rst_di", di, 0);
        rst = 1'b0;

        // single item read-modify-write: (FFFF & 1000) | (0041 & EFFF) = 1041
        @(negedge dclk);
        pulse_sen();
        chk("t1_start", {busy, pll_rst, cfg_ready, serr}, 4'b1110);
        send_item(7'h08, 16'h1000, 16'h0041, 1'b1);
        wait_sig(0, 400, "t1_lock_entry");
        chk("t1_n_rd", n_rd, 1);
        chk("t1_n_wr", n_wr, 1);
        chk("t1_rd_addr", rd_log[0], 7'h08);
        chk("t1_wr_addr", wr_alog[0], 7'h08);
        chk("t1_wr_data", wr_dlog[0], 16'h1041);
        chk("t1_rst_in_write", wr_rstlog[0], 1);
        chk("t1_hold", {daddr, di, den}, {7'h08, 16'h1041, 1'b0});
        locked = 1'b1;
        @(negedge dclk);
        chk("t1_srdy", {srdy, busy}, 2'b11);
        @(negedge dclk);
        chk("t1_srdy_end", {srdy, busy}, 2'b00);
        chk("t1_n_srdy", n_srdy, 1);
        locked = 1'b0;

        // three items, 10 idle cycles in FETCH between them
        r0 = n_rd;
        w0 = n_wr;
        pulse_sen();
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                wait_sig(3, 300, "t2_ready_timeout");
                cnt = 0;
                repeat (10) begin
                    @(negedge dclk);
                    if (cfg_ready && busy && !den) cnt++;
                end
                chk("t2_fetch_hold", cnt, 10);
            end
            send_item(t2_a[i], t2_m[i], t2_d[i], (i == 2));
        end
        wait_sig(0, 400, "t2_lock_entry");
        chk("t2_n_rd", n_rd - r0, 3);
        chk("t2_n_wr", n_wr - w0, 3);
        for (int j = 0; j < 3; j++) begin
            chk("t2_rd_addr", rd_log[r0 + j], t2_a[j]);
            chk("t2_wr_addr", wr_alog[w0 + j], t2_a[j]);
            chk("t2_wr_data", wr_dlog[w0 + j], t2_e[j]);
        end
        finish_lock("t2");

        // DRDY never answers the read: serr 64 cycles into WAIT_R (65 after the READ cycle)
        resp_en = 1'b0;
        r0 = n_rd;
        w0 = n_wr;
        pulse_sen();
        send_item(7'h20, 16'hFFFF, 16'h0000, 1'b1);
        cnt = 0;
        while (!serr && cnt < 300) begin
            @(negedge dclk);
            cnt++;
        end
        chk("t3_serr_latency", cnt, 65);
        chk("t3_flags", {serr, pll_rst, busy}, 3'b100);
        chk("t3_one_read", n_rd - r0, 1);
        chk("t3_no_write", n_wr - w0, 0);
        resp_en = 1'b1;
        @(negedge dclk);

        // LOCKED never rises: serr after 4096 cycles in LOCK, then a clean retry
        pulse_sen();
        chk("t4_serr_cleared", {serr, busy}, 2'b01);
        send_item(7'h21, 16'h0000, 16'h1111, 1'b1);
        wait_sig(0, 400, "t4_lock_entry");
        cnt = 0;
        while (!serr && cnt < 5000) begin
            @(negedge dclk);
            cnt++;
        end
        chk("t4_lock_timeout", cnt, 4096);
        chk("t4_flags", {serr, pll_rst, busy}, 3'b100);
        repeat (5) @(negedge dclk);
        chk("t4_serr_sticky", serr, 1);
        pulse_sen();
        chk("t4_retry_start", {serr, busy}, 2'b01);
        w0 = n_wr;
        send_item(7'h22, 16'h0000, 16'hBEEF, 1'b1);
        wait_sig(0, 400, "t4_retry_lock");
        chk("t4_retry_data", wr_dlog[w0], 16'hBEEF);
        finish_lock("t4");
        chk("t4_retry_serr", serr, 0);

        // reset in WAIT_W, SEN while busy, stray DRDY in IDLE
        lat = 5;
        pulse_sen();
        pulse_sen();
        chk("t5_sen_busy", {busy, cfg_ready, pll_rst}, 3'b111);
        w0 = n_wr;
        wait_tgt = w0 + 1;
        send_item(7'h30, 16'h00FF, 16'h1200, 1'b0);
        wait_sig(4, 200, "t5_write_timeout");
        chk("t5_wr_data", wr_dlog[w0], 16'h12F3);
        @(negedge dclk);
        #1 rst = 1'b1;
        #1;
        chk("t5_rst_flags", {den, dwe, pll_rst, cfg_ready, busy, srdy, serr}, 0);
        chk("t5_rst_daddr", daddr, 0);
        chk("t5_rst_di", di, 0);
        r0 = n_rd;
        w0 = n_wr;
        s0 = n_srdy;
        @(negedge dclk);
        rst = 1'b0;
        repeat (12) @(negedge dclk);
        chk("t5_no_drp", (n_rd - r0) + (n_wr - w0), 0);
        chk("t5_no_srdy", n_srdy - s0, 0);
        drdy_force = 1'b1;
        repeat (3) @(negedge dclk);
        drdy_force = 1'b0;
        @(negedge dclk);
        chk("t5_stray_drdy", {busy, den, cfg_ready, serr, pll_rst}, 0);

        // SEN accepted on the first edge after reset falls
        lat = 2;
        #1 rst = 1'b1;
        @(negedge dclk);
        rst = 1'b0;
        pulse_sen();
        chk("t5_sen_after_rst", {busy, pll_rst}, 2'b11);
        w0 = n_wr;
        send_item(7'h31, 16'hF0F0, 16'h0A0A, 1'b1);
        wait_sig(0, 400, "t5_lock_entry");
        chk("t5_final_data", wr_dlog[w0], 16'hCAFA);
        finish_lock("t5");

        chk("one_outstanding", n_ovl, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
        $fatal(1);
    end

endmodule
